axilite_slave_regs: RTL and testbench

AXILITE_SLAVE_REGS -- requirements
Module: axilite_slave_regs

---
 rtl/axilite_regs_pkg.sv | 19 +
 rtl/axilite_addr_decode.sv | 24 ++
 rtl/axilite_slave_regs.sv | 128 ++++++++++++
 tb/tb_axilite_slave_regs.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/axilite_regs_pkg.sv
// axilite_regs_pkg: shared register map, response codes and FSM states for the AXI-Lite register slave
package axilite_regs_pkg;
  localparam logic [4:0] OFF_ID      = 5'h00;
  localparam logic [4:0] OFF_SCRATCH = 5'h04;
  localparam logic [4:0] OFF_CTRL    = 5'h08;
  localparam logic [4:0] OFF_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_WRCNT   = 5'h10;
  localparam logic [4:0] OFF_LAST    = 5'h13;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {SEL_ID, SEL_SCRATCH, SEL_CTRL, SEL_STATUS, SEL_WRCNT} reg_sel_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/axilite_addr_decode.sv
// axilite_addr_decode: maps an AXI address onto a register select and an in-window hit flag
//   i_addr : byte address (low two bits ignored)
//   o_sel  : selected register
//   o_hit  : address lies inside the 0x00..0x13 window above C_BASE_ADDR
module axilite_addr_decode
  import axilite_regs_pkg::*;
#(
  parameter int                      C_ADDR_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = 32'h44A00000
) (
  input  logic [C_ADDR_WIDTH-1:0] i_addr,
  output reg_sel_t                o_sel,
  output logic                    o_hit
);
  logic [C_ADDR_WIDTH-1:0] w_off;
  // addresses below the base wrap to a huge offset, so one unsigned compare covers both ends
  assign w_off = i_addr - C_BASE_ADDR;
  assign o_hit = w_off <= C_ADDR_WIDTH'(OFF_LAST);
  assign o_sel = w_off[4:2] == OFF_SCRATCH[4:2] ? SEL_SCRATCH :
                 w_off[4:2] == OFF_CTRL[4:2]    ? SEL_CTRL    :
                 w_off[4:2] == OFF_STATUS[4:2]  ? SEL_STATUS  :
                 w_off[4:2] == OFF_WRCNT[4:2]   ? SEL_WRCNT   :
                 w_off[4:2] == OFF_ID[4:2]      ? SEL_ID      : SEL_ID;
endmodule

// File: rtl/axilite_slave_regs.sv
// axilite_slave_regs: AXI4-Lite slave with ID, SCRATCH, CTRL, STATUS and WR_COUNT registers
//   clk, rst          : clock, synchronous active-high reset
//   s_axi_aw*/w*/b*   : write address, data and response channels
//   s_axi_ar*/r*      : read address and data channels
//   ctrl_o            : CTRL register contents
//   status_i          : live status, sampled when STATUS is read
module axilite_slave_regs
  import axilite_regs_pkg::*;
#(
  parameter int                      C_ADDR_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = 32'h44A00000,
  parameter logic [31:0]             C_ID_VALUE   = 32'h01234567
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             ctrl_o,
  input  logic [31:0]             status_i
);
  w_state_t                r_wstate;
  r_state_t                r_rstate;
  logic                    r_en;
  logic                    r_aw_have, r_w_have;
  logic [C_ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]             r_wdata, r_scratch, r_ctrl, r_wrcnt, r_rdata;
  logic [3:0]              r_wstrb;
  logic                    r_bvalid, r_rvalid;
  logic [1:0]              r_bresp, r_rresp;
  reg_sel_t                w_wsel, w_rsel;
  logic                    w_whit, w_rhit;
  logic [31:0]             w_rval;
  axilite_addr_decode #(.C_ADDR_WIDTH(C_ADDR_WIDTH), .C_BASE_ADDR(C_BASE_ADDR)) u_wdec (
    .i_addr(r_awaddr), .o_sel(w_wsel), .o_hit(w_whit)
  );
  axilite_addr_decode #(.C_ADDR_WIDTH(C_ADDR_WIDTH), .C_BASE_ADDR(C_BASE_ADDR)) u_rdec (
    .i_addr(s_axi_araddr), .o_sel(w_rsel), .o_hit(w_rhit)
  );
  // r_en holds every ready low until the first clock after reset is released
  assign s_axi_awready = r_en && r_wstate == W_IDLE && !r_aw_have;
  assign s_axi_wready  = r_en && r_wstate == W_IDLE && !r_w_have;
  assign s_axi_arready = r_en && r_rstate == R_IDLE;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign ctrl_o        = r_ctrl;
  always_comb
    w_rval = !w_rhit                ? 32'h0     :
             w_rsel == SEL_SCRATCH  ? r_scratch :
             w_rsel == SEL_CTRL     ? r_ctrl    :
             w_rsel == SEL_STATUS   ? status_i  :
             w_rsel == SEL_WRCNT    ? r_wrcnt   : C_ID_VALUE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_wstate  <= W_IDLE;
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_scratch <= '0;
      r_ctrl    <= '0;
      r_wrcnt   <= '0;
    end else begin
      r_en <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        r_aw_have <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        r_w_have <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (r_wstate == W_IDLE && r_aw_have && r_w_have) begin
        r_aw_have <= 1'b0;
        r_w_have  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_whit ? RESP_OKAY : RESP_SLVERR;
        r_wstate  <= W_RESP;
        if (w_whit) begin
          r_wrcnt <= r_wrcnt + 32'd1;
          if (w_wsel == SEL_SCRATCH) r_scratch <= apply_wstrb(r_scratch, r_wdata, r_wstrb);
          if (w_wsel == SEL_CTRL) r_ctrl <= apply_wstrb(r_ctrl, r_wdata, r_wstrb);
        end
      end else if (r_wstate == W_RESP && s_axi_bready) begin
        r_bvalid <= 1'b0;
        r_wstate <= W_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (r_rstate == R_IDLE && s_axi_arvalid && s_axi_arready) begin
      r_rdata  <= w_rval;
      r_rresp  <= w_rhit ? RESP_OKAY : RESP_SLVERR;
      r_rvalid <= 1'b1;
      r_rstate <= R_DATA;
    end else if (r_rstate == R_DATA && s_axi_rready) begin
      r_rvalid <= 1'b0;
      r_rstate <= R_IDLE;
    end
  end
endmodule

// File: tb/tb_axilite_slave_regs.sv
// tb_axilite_slave_regs: directed self-checking bench for axilite_slave_regs
module tb_axilite_slave_regs;
  localparam logic [31:0] BASE    = 32'h44A00000;
  localparam logic [31:0] A_ID    = BASE + 32'h00;
  localparam logic [31:0] A_SCR   = BASE + 32'h04;
  localparam logic [31:0] A_CTRL  = BASE + 32'h08;
  localparam logic [31:0] A_STAT  = BASE + 32'h0C;
  localparam logic [31:0] A_WRCNT = BASE + 32'h10;
  logic        clk = 0, rst = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, ctrl_o, status_i = 0;
  logic [3:0]  wstrb = 0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0]  bresp, rresp;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] d;
  logic [1:0]  r;
  always #5 clk = ~clk;
  axilite_slave_regs dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ctrl_o(ctrl_o), .status_i(status_i)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic axi_write(input logic [31:0] a, input logic [31:0] dv, input logic [3:0] s, output logic [1:0] resp);
    int n;
    logic ah, wh;
    awaddr = a; wdata = dv; wstrb = s; awvalid = 1; wvalid = 1; bready = 1; resp = 2'bxx;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awready; wh = wready;
      tick();
      if (ah) awvalid = 0;
      if (wh) wvalid = 0;
      n++;
    end
    check("wr_addr_data_accepted", {31'd0, awvalid || wvalid}, 32'd0);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    check("wr_bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    tick();
    bready = 0;
  endtask
  task automatic axi_read(input logic [31:0] a, output logic [31:0] dv, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    check("rd_arready_seen", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 0;
    check("rd_one_cycle_latency", {31'd0, rvalid}, 32'd1);
    dv = rdata; resp = rresp;
    tick();
    rready = 0;
  endtask
  initial begin
    repeat (3) tick();
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_bresp_rresp", {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ctrl_o", ctrl_o, 32'd0);
    rst = 0;
    tick();
    check("post_rst_awready", {31'd0, awready}, 32'd1);
    check("post_rst_wready", {31'd0, wready}, 32'd1);
    check("post_rst_arready", {31'd0, arready}, 32'd1);
    axi_write(A_SCR, 32'h4b, 4'hF, r); check("scr_wr1_resp", {30'd0, r}, 32'd0);
    axi_write(A_SCR, 32'h36, 4'hF, r); check("scr_wr2_resp", {30'd0, r}, 32'd0);
    axi_write(A_SCR, 32'h98, 4'hF, r); check("scr_wr3_resp", {30'd0, r}, 32'd0);
    axi_read(A_SCR, d, r); check("scr_rd_data", d, 32'h98); check("scr_rd_resp", {30'd0, r}, 32'd0);
    axi_read(A_WRCNT, d, r); check("wrcnt_after_3", d, 32'd3);
    axi_read(A_ID, d, r); check("id_rd_data", d, 32'h01234567); check("id_rd_resp", {30'd0, r}, 32'd0);
    axi_write(A_ID, 32'hDEAD, 4'hF, r); check("id_wr_resp_okay", {30'd0, r}, 32'd0);
    axi_read(A_ID, d, r); check("id_unchanged", d, 32'h01234567);
    axi_read(A_WRCNT, d, r); check("wrcnt_counts_ro_write", d, 32'd4);
    axi_write(A_CTRL, 32'h0, 4'hF, r);
    axi_write(A_CTRL, 32'hAABBCCDD, 4'b0101, r); check("ctrl_strb_resp", {30'd0, r}, 32'd0);
    check("ctrl_o_strb", ctrl_o, 32'h00BB00DD);
    axi_read(A_CTRL, d, r); check("ctrl_rd_strb", d, 32'h00BB00DD);
    axi_write(A_CTRL, 32'h11223344, 4'b0000, r); check("ctrl_strb0_resp", {30'd0, r}, 32'd0);
    check("ctrl_o_strb0_unchanged", ctrl_o, 32'h00BB00DD);
    status_i = 32'hCAFEF00D;
    axi_read(A_STAT, d, r); check("status_rd", d, 32'hCAFEF00D);
    axi_read(BASE + 32'h07, d, r); check("low_addr_bits_ignored", d, 32'h98);
    axi_read(BASE + 32'h20, d, r); check("unmapped_rd_resp", {30'd0, r}, 32'h2); check("unmapped_rd_data", d, 32'd0);
    axi_read(BASE + 32'h14, d, r); check("edge_0x14_rd_resp", {30'd0, r}, 32'h2);
    axi_read(BASE - 32'h4, d, r); check("below_base_rd_resp", {30'd0, r}, 32'h2); check("below_base_rd_data", d, 32'd0);
    axi_write(BASE + 32'h100, 32'h12345678, 4'hF, r); check("unmapped_wr_resp", {30'd0, r}, 32'h2);
    axi_read(A_WRCNT, d, r); check("wrcnt_unmapped_ignored", d, 32'd7);
    awaddr = A_SCR; wdata = 32'h55; wstrb = 4'hF; wvalid = 1; bready = 0;
    tick();
    wvalid = 0;
    check("w_first_wready_dropped", {31'd0, wready}, 32'd0);
    tick(); tick();
    check("w_first_no_bvalid_yet", {31'd0, bvalid}, 32'd0);
    awvalid = 1;
    tick();
    awvalid = 0;
    for (int n = 0; n < 20 && !bvalid; n++) tick();
    check("w_first_bvalid", {31'd0, bvalid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bready_low_bvalid_hold", {29'd0, bvalid, bresp}, 32'h4);
    end
    bready = 1;
    tick();
    bready = 0;
    check("bvalid_cleared", {31'd0, bvalid}, 32'd0);
    axi_read(A_WRCNT, d, r); check("w_first_single_commit", d, 32'd8);
    axi_read(A_SCR, d, r); check("w_first_data", d, 32'h55);
    awaddr = A_SCR; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; araddr = A_SCR; arvalid = 1;
    tick();
    arvalid = 0;
    check("concurrent_bvalid", {31'd0, bvalid}, 32'd1);
    check("concurrent_rvalid", {31'd0, rvalid}, 32'd1);
    check("concurrent_pre_write_value", rdata, 32'h55);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    axi_read(A_SCR, d, r); check("concurrent_post_write", d, 32'h77);
    araddr = A_SCR; arvalid = 1;
    tick();
    arvalid = 0;
    tick();
    check("rvalid_hold_before_rst", {31'd0, rvalid}, 32'd1);
    check("rdata_hold_before_rst", rdata, 32'h77);
    rst = 1;
    tick();
    check("rst_mid_read_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_mid_read_arready", {31'd0, arready}, 32'd0);
    rst = 0;
    tick();
    check("rst_release_arready", {31'd0, arready}, 32'd1);
    check("rst_ctrl_cleared", ctrl_o, 32'd0);
    axi_read(A_SCR, d, r); check("rst_scratch_cleared", d, 32'd0);
    axi_read(A_WRCNT, d, r); check("rst_wrcnt_cleared", d, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
